// File: rtl/shift_seq.sv
// Iterative RV32I shift sequencer: moves at most STEP bit positions per cycle
// between a valid/ready issue port and a valid/ready result port.
module shift_seq #(
    parameter int unsigned STEP = 4,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            funct7_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            illegal_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic [1:0] {ModeSll, ModeSrl, ModeSra} mode_e;

    localparam logic [4:0] StepAmt = 5'(STEP);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [4:0]        rem_q, rem_d;
    logic              illegal_q, illegal_d;

    logic              req_illegal;
    mode_e             req_mode;
    logic [4:0]        step_k;
    logic [XLEN-1:0]   acc_shifted;

    // Only the low five bits of the shift amount are architecturally meaningful.
    logic unused_op2;
    assign unused_op2 = ^op2_i[XLEN-1:5];

    always_comb begin
        req_illegal = 1'b0;
        req_mode    = ModeSll;
        case (funct3_i)
            3'b001:  req_mode = ModeSll;
            3'b101:  req_mode = funct7_i ? ModeSra : ModeSrl;
            default: req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        step_k      = (rem_q < StepAmt) ? rem_q : StepAmt;
        acc_shifted = acc_q;
        case (mode_q)
            ModeSll: acc_shifted = acc_q << step_k;
            ModeSrl: acc_shifted = acc_q >> step_k;
            ModeSra: acc_shifted = XLEN'($signed(acc_q) >>> step_k);
            default: acc_shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        illegal_d = illegal_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        acc_d     = op1_i;
                        rem_d     = op2_i[4:0];
                        mode_d    = req_mode;
                        illegal_d = req_illegal;
                        state_d   = (req_illegal || op2_i[4:0] == 5'd0) ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    acc_d = acc_shifted;
                    rem_d = rem_q - step_k;
                    if (rem_q == step_k) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (res_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            rem_q     <= '0;
            mode_q    <= ModeSll;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            illegal_q <= illegal_d;
        end
    end

    // Result is gated so intermediate accumulator values never leak out.
    assign req_ready_o = (state_q == StIdle);
    assign res_valid_o = (state_q == StDone);
    assign res_o       = res_valid_o ? acc_q : '0;
    assign illegal_o   = res_valid_o & illegal_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases, randomized ops against a
// behavioural model, backpressure, flush and asynchronous reset scenarios.
module tb_shift_seq;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;
    logic        illegal;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_seq #(.STEP(STEP), .XLEN(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .op1_i       (op1),
        .op2_i       (op2),
        .flush_i     (flush),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res),
        .illegal_o   (illegal),
        .busy_o      (busy)
    );

    // Whole-operation model: final value and latency straight from the ISA rules.
    function automatic void model(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = !(f3 == 3'b001 || f3 == 3'b101);
        if (ill)               r = a;
        else if (f3 == 3'b001) r = a << sh;
        else if (f7)           r = 32'($signed(a) >>> sh);
        else                   r = a >> sh;
        lat = (ill || sh == 0) ? 1 : 1 + (sh + int'(STEP) - 1) / int'(STEP);
    endfunction

    task automatic do_op(input string name, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eil;
        int          elat;
        int          lat;
        bit          got;
        model(f3, f7, a, b, er, eil, elat);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s idle_wait: req_ready never high", name);
            return;
        end
        req_valid = 1'b1; funct3 = f3; funct7 = f7; op1 = a; op2 = b;
        @(posedge clk);
        #1;
        // Scramble operands after accept; they must not matter any more.
        req_valid = 1'b0; funct3 = 3'($urandom); funct7 = 1'($urandom);
        op1 = $urandom; op2 = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                lat = n;
                break;
            end
            n_cmp++;
            if ({res, illegal, busy, req_ready} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL %s wait_outputs: res=%h ill=%b busy=%b rdy=%b required 0/0/1/0",
                         name, res, illegal, busy, req_ready);
            end
        end
        n_cmp++;
        if (lat !== elat) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
        end
        if (lat == 0) return;
        n_cmp++;
        if ({res, illegal} !== {er, eil}) begin
            n_err++;
            $display("FAIL %s result: res=%h ill=%b required res=%h ill=%b",
                     name, res, illegal, er, eil);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_cmp++;
            if ({res_valid, res, illegal, req_ready, busy} !== {1'b1, er, eil, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL %s hold%0d: v=%b res=%h ill=%b rdy=%b required 1/%h/%b/0",
                         name, h, res_valid, res, illegal, req_ready, er, eil);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, res_valid, busy, res} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL %s release: rdy=%b v=%b busy=%b res=%h required 1/0/0/0",
                     name, req_ready, res_valid, busy, res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'b0; funct7 = 1'b0;
        op1 = '0; op2 = '0; flush = 1'b0; res_ready = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, res_valid, res, illegal, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b v=%b res=%h ill=%b busy=%b required 1/0/0/0/0",
                     req_ready, res_valid, res, illegal, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op("sll5",  3'b001, 1'b0, 32'h0000_0001, 32'hFFFF_FFE5, 0);
        do_op("sra31", 3'b101, 1'b1, 32'h8000_0000, 32'h0000_001F, 0);
        do_op("srl31", 3'b101, 1'b0, 32'h8000_0000, 32'h0000_001F, 0);
        do_op("sh0",   3'b001, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        do_op("ill",   3'b000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0007, 0);
        do_op("sll4",  3'b001, 1'b1, 32'h0000_00F1, 32'h0000_0004, 0);
    endtask

    task automatic test_backpressure();
        do_op("bp_sra", 3'b101, 1'b1, 32'h9234_5678, 32'h0000_000D, 5);
        do_op("bp_ill", 3'b111, 1'b1, 32'hCAFE_F00D, 32'h0000_0003, 5);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: f3 = 3'b001;
                4, 5, 6, 7: f3 = 3'b101;
                default:    f3 = 3'($urandom);
            endcase
            do_op($sformatf("rand%0d", i), f3, 1'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_flush_busy();
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b001; funct7 = 1'b0; op1 = 32'h1; op2 = 32'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if ({req_ready, busy, res_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL flush_busy: rdy=%b busy=%b v=%b required 1/0/0",
                     req_ready, busy, res_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_busy_quiet%0d: v=%b required 0", i, res_valid);
            end
        end
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b001; funct7 = 1'b0; op1 = 32'h1234_5678; op2 = 32'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({res_valid, res} !== {1'b1, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL flush_done_pre: v=%b res=%h required 1/12345678", res_valid, res);
        end
        flush = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({res_valid, req_ready, busy} !== 3'b010) begin
                n_err++;
                $display("FAIL flush_done%0d: v=%b rdy=%b busy=%b required 0/1/0",
                         i, res_valid, req_ready, busy);
            end
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; funct3 = 3'b001; op1 = 32'h5; op2 = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({res_valid, req_ready, busy} !== 3'b010) begin
                n_err++;
                $display("FAIL flush_idle%0d: v=%b rdy=%b busy=%b required 0/1/0",
                         i, res_valid, req_ready, busy);
            end
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b001; funct7 = 1'b0; op1 = 32'h1; op2 = 32'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, res_valid, res, illegal, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_busy: rdy=%b v=%b res=%h ill=%b busy=%b required 1/0/0/0/0",
                     req_ready, res_valid, res, illegal, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({res_valid, req_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL reset_busy_after%0d: v=%b rdy=%b required 0/1",
                         i, res_valid, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush_busy();
        test_flush_done();
        test_flush_idle();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle controller that sequences RV32I shift operations (SLL/SRL/SRA) through a narrow iterative shift stage.
- The stage moves at most STEP bit positions per cycle, replacing a full 32-bit barrel shifter in area-constrained builds.
- Sits between the decode/issue stage and writeback.
- Uses a valid/ready handshake on both sides; supports pipeline flush.

Parameters:
- STEP, 4, maximum bit positions shifted per BUSY cycle; legal values 1, 2, 4, 8, 16.
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  issue presents a shift op.
- req_ready_o  out  1  block can accept an op; high only in IDLE.
- funct3_i  in  3  3'b001 = SLL, 3'b101 = SRL/SRA; all other codes are illegal.
- funct7_i  in  1  instruction bit 30; 1 selects SRA when funct3 = 101; ignored for SLL.
- op1_i  in  XLEN  value to shift.
- op2_i  in  XLEN  shift amount; only [4:0] is used, upper bits are ignored.
- flush_i  in  1  synchronous abort of any in-flight op.
- res_valid_o  out  1  result is available.
- res_ready_i  in  1  writeback consumes the result.
- res_o  out  XLEN  shift result.
- illegal_o  out  1  qualifies res_valid_o; the op had an unsupported funct3.
- busy_o  out  1  high in BUSY or DONE.

Behaviour:
- Reset: the asynchronous assertion of rst_n_i sets the following, regardless of clock:
  - state = IDLE
  - req_ready_o = 1
  - res_valid_o = 0, res_o = 0, illegal_o = 0, busy_o = 0
  - internal acc = 0, rem = 0, mode = 0
- Reset deassertion is synchronous to clk_i.
- Reset during BUSY or DONE discards the op; no result is produced.
- States: IDLE, BUSY, DONE.
- Accept: occurs in IDLE when req_valid_i & req_ready_o & !flush_i. On that edge:
  - acc <= op1_i
  - rem <= op2_i[4:0]
  - mode <= {SLL, SRL, SRA} decoded from funct3_i/funct7_i
  - illegal <= (funct3_i not in {001, 101})
- Next state after accept:
  - DONE if illegal, or if op2_i[4:0] == 0;
  - otherwise BUSY.
- BUSY, each edge:
  - k = min(rem, STEP)
  - acc shifted by k: SLL zero-fills from LSB; SRL zero-fills from MSB; SRA replicates acc[31] into the vacated positions.
  - rem <= rem - k
  - When rem - k == 0, next state is DONE.
- DONE:
  - res_valid_o = 1; res_o = acc (op1 unchanged if illegal); illegal_o = illegal.
  - All three outputs stay stable until res_ready_i is sampled high.
  - On that edge, next state is IDLE.
  - A new request is not accepted in the same cycle; req_ready_o is low in DONE.
- Latency from the accept cycle to the first res_valid_o cycle: 1 + ceil(shamt/STEP), with shamt = 0 or illegal giving 1.
  - STEP = 4, shamt = 31 → 9 cycles.
  - STEP = 1, shamt = 31 → 32 cycles.
- Throughput: one op per (latency + 1) cycles minimum, because DONE → IDLE costs one cycle.
- flush_i has top priority in every state. On that edge, next state is IDLE, res_valid_o deasserts, and acc/rem are left don't-care.
- flush_i concurrent with req_valid_i in IDLE: the request is not accepted.
- flush_i concurrent with res_ready_i in DONE: the result is dropped. Writeback must treat the flush as winning.
- res_o is 0 whenever res_valid_o = 0; it must not expose intermediate acc values.
- busy_o = (state != IDLE).
- Outputs are registered or depend on state only; no combinational path from req_valid_i to req_ready_o.
- Inputs other than handshake signals are sampled only at accept; changes during BUSY have no effect.

Test Plan:
- Reset mid-BUSY: SLL op1=0x1, op2=20, STEP=4; assert rst_n_i=0 two cycles after accept → outputs immediately at reset values; after release, req_ready_o=1 and no res_valid_o ever appears.
- SLL op1=0x0000_0001, op2=0xFFFF_FFE5 (shamt 5), STEP=4 → res_valid_o 3 cycles after accept; res_o=0x0000_0020, illegal_o=0.
- SRA op1=0x8000_0000, funct7=1, shamt 31, STEP=4 → res_o=0xFFFF_FFFF after 9 cycles; same op as SRL (funct7=0) → res_o=0x0000_0001.
- shamt 0 and illegal funct3=3'b000 with op1=0xDEAD_BEEF → both give res_o=0xDEAD_BEEF, latency 1; illegal_o=0 and 1 respectively.
- Backpressure: result ready, res_ready_i held low 5 cycles → res_o, res_valid_o and illegal_o stable all 5 cycles; req_ready_o=0 throughout; IDLE one cycle after res_ready_i=1.
- Flush: flush_i pulsed in the 2nd BUSY cycle of SLL shamt 20 → IDLE next cycle, no res_valid_o; flush_i with res_ready_i in DONE → no handshake completes; flush_i with req_valid_i in IDLE → op not accepted.
